fll_cfg_ctrl: RTL and testbench

//  Bus-side configuration front end that sits directly upstream of the FLL wrapper.

---
 rtl/fll_cfg_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_fll_cfg_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fll_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fll_cfg_ctrl                                                    |
// | Purpose  : Host register front end for the FLL wrapper: req/ack handshake, |
// |            output gating and lock wait after a divider write.              |
// | Options  : FLL_CFG_LOCK_IRQ_EN enables the sticky lock-loss interrupt.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fll_cfg_ctrl #(
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        fll_req_o,
  input  logic        fll_ack_i,
  output logic [1:0]  fll_addr_o,
  output logic [31:0] fll_wdata_o,
  output logic        fll_wr_no,
  input  logic [31:0] fll_rdata_i,
  input  logic        fll_lock_i,
  output logic        fll_oe_o,
  output logic        lock_irq_o
);

  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > LOCK_TIMEOUT) ? ACK_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_LOCK = 2'd2,
    S_RESP      = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              we_q;
  logic [1:0]        addr_q;
  logic [31:0]       wdata_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              fll_req_q;
  logic              fll_wr_n_q;
  logic              fll_oe_q;
  logic              lock_meta_q;
  logic              lock_sync_q;
  logic              local_wr_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  end

`ifdef FLL_CFG_LOCK_IRQ_EN
  // Addr 3 writes only clear the interrupt and never reach the FLL.
  assign local_wr_d = we_i && (addr_i == 2'd3);
`else
  assign local_wr_d = 1'b0;
`endif

  assign gnt_o       = (state_q == S_IDLE) && req_i;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign fll_req_o   = fll_req_q;
  assign fll_addr_o  = addr_q;
  assign fll_wdata_o = wdata_q;
  assign fll_wr_no   = fll_wr_n_q;
  assign fll_oe_o    = fll_oe_q;

  // fll_lock_i comes from the FLL analog domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      lock_meta_q <= fll_lock_i;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 32'd0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'd0;
      err_q      <= 1'b0;
      fll_req_q  <= 1'b0;
      fll_wr_n_q <= 1'b1;
      fll_oe_q   <= 1'b1;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            if (local_wr_d) begin
              state_q  <= S_RESP;
              rvalid_q <= 1'b1;
            end else begin
              state_q    <= S_REQ;
              fll_req_q  <= 1'b1;
              fll_wr_n_q <= ~we_i;
            end
          end
        end
        S_REQ: begin
          if (fll_ack_i) begin
            fll_req_q  <= 1'b0;
            fll_wr_n_q <= 1'b1;
            cnt_q      <= '0;
            if (we_q && (addr_q == 2'd0)) begin
              state_q  <= S_WAIT_LOCK;
              fll_oe_q <= 1'b0;
            end else begin
              state_q  <= S_RESP;
              rvalid_q <= 1'b1;
              rdata_q  <= we_q ? 32'd0 : fll_rdata_i;
            end
          end else if (cnt_q == ACK_LAST) begin
            fll_req_q  <= 1'b0;
            fll_wr_n_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_RESP;
            rvalid_q   <= 1'b1;
            err_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_LOCK: begin
          // Lock is tested first so it wins over a simultaneous timeout.
          if (lock_sync_q || (cnt_q == LOCK_LAST)) begin
            state_q  <= S_RESP;
            rvalid_q <= 1'b1;
            err_q    <= ~lock_sync_q;
            fll_oe_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FLL_CFG_LOCK_IRQ_EN
  logic lock_prev_q;
  logic irq_q;

  // A new lock-loss event takes precedence over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_prev_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      lock_prev_q <= lock_sync_q;
      if (lock_prev_q && !lock_sync_q && (state_q != S_WAIT_LOCK)) begin
        irq_q <= 1'b1;
      end else if (gnt_o && local_wr_d) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign lock_irq_o = irq_q;
`else
  assign lock_irq_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fll_cfg_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fll_cfg_ctrl                                                 |
// | Purpose  : Directed self-checking bench for fll_cfg_ctrl.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fll_cfg_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        fll_req_o;
  logic        fll_ack_i;
  logic [1:0]  fll_addr_o;
  logic [31:0] fll_wdata_o;
  logic        fll_wr_no;
  logic [31:0] fll_rdata_i;
  logic        fll_lock_i;
  logic        fll_oe_o;
  logic        lock_irq_o;

  int n_vec = 0;
  int n_err = 0;
  int cnt_a;
  int cnt_b;
  int cnt_bad;

  fll_cfg_ctrl #(
    .ACK_TIMEOUT (16),
    .LOCK_TIMEOUT(64)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .fll_req_o  (fll_req_o),
    .fll_ack_i  (fll_ack_i),
    .fll_addr_o (fll_addr_o),
    .fll_wdata_o(fll_wdata_o),
    .fll_wr_no  (fll_wr_no),
    .fll_rdata_i(fll_rdata_i),
    .fll_lock_i (fll_lock_i),
    .fll_oe_o   (fll_oe_o),
    .lock_irq_o (lock_irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host(input logic we, input logic [1:0] addr, input logic [31:0] wdata);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wdata;
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_i       = 1'b0;
    we_i        = 1'b0;
    addr_i      = 2'd0;
    wdata_i     = 32'd0;
    fll_ack_i   = 1'b0;
    fll_rdata_i = 32'd0;
    fll_lock_i  = 1'b1;
    step();
    step();

    chk("rst_req",    fll_req_o,  0);
    chk("rst_wr_n",   fll_wr_no,  1);
    chk("rst_oe",     fll_oe_o,   1);
    chk("rst_rvalid", rvalid_o,   0);
    chk("rst_rdata",  rdata_o,    0);
    chk("rst_err",    err_o,      0);
    chk("rst_gnt",    gnt_o,      0);
    chk("rst_irq",    lock_irq_o, 0);

    rst_ni = 1'b1;
    step(); step(); step();

    // Read addr 2 with immediate ack: rvalid two cycles after grant.
    host(1'b0, 2'd2, 32'd0);
    fll_ack_i   = 1'b1;
    fll_rdata_i = 32'h0000_00A5;
    #1;
    chk("t1_gnt", gnt_o, 1);
    step();
    req_i = 1'b0;
    chk("t1_fll_req",  fll_req_o,  1);
    chk("t1_fll_wr_n", fll_wr_no,  1);
    chk("t1_fll_addr", fll_addr_o, 2);
    chk("t1_rvalid0",  rvalid_o,   0);
    step();
    chk("t1_rvalid", rvalid_o,  1);
    chk("t1_rdata",  rdata_o,   32'hA5);
    chk("t1_err",    err_o,     0);
    chk("t1_req_lo", fll_req_o, 0);
    step();
    chk("t1_rvalid_pulse", rvalid_o, 0);
    chk("t1_rdata_clr",    rdata_o,  0);
    fll_ack_i = 1'b0;

    // Divider write, lock drops beforehand and rises 10 cycles into the wait.
    fll_lock_i = 1'b0;
    step(); step(); step();
    host(1'b1, 2'd0, 32'h3);
    fll_ack_i = 1'b1;
    #1;
    chk("t2_gnt", gnt_o, 1);
    step();
    req_i = 1'b0;
    chk("t2_fll_req",   fll_req_o,   1);
    chk("t2_fll_wr_n",  fll_wr_no,   0);
    chk("t2_fll_wdata", fll_wdata_o, 32'h3);
    chk("t2_oe_req",    fll_oe_o,    1);
    step();
    fll_ack_i = 1'b0;
    chk("t2_oe_wait",  fll_oe_o,  0);
    chk("t2_req_wait", fll_req_o, 0);
    cnt_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fll_oe_o !== 1'b0 || rvalid_o !== 1'b0) cnt_bad++;
    end
    chk("t2_wait_stable", cnt_bad, 0);
    fll_lock_i = 1'b1;
    step(); step();
    chk("t2_sync_delay", rvalid_o, 0);
    step();
    chk("t2_rvalid", rvalid_o, 1);
    chk("t2_err",    err_o,    0);
    chk("t2_oe_ret", fll_oe_o, 1);
    step();
    chk("t2_oe_idle", fll_oe_o, 1);

    // Divider write with lock held low: timeout after exactly 64 wait cycles.
    fll_lock_i = 1'b0;
    step(); step(); step();
    host(1'b1, 2'd0, 32'h7);
    fll_ack_i = 1'b1;
    step();
    req_i = 1'b0;
    step();
    fll_ack_i = 1'b0;
    chk("t3_oe_enter", fll_oe_o, 0);
    cnt_bad = 0;
    for (int i = 1; i < 64; i++) begin
      step();
      if (fll_oe_o !== 1'b0 || rvalid_o !== 1'b0) cnt_bad++;
    end
    chk("t3_wait_63", cnt_bad, 0);
    step();
    chk("t3_rvalid", rvalid_o, 1);
    chk("t3_err",    err_o,    1);
    chk("t3_oe_ret", fll_oe_o, 1);
    fll_lock_i = 1'b1;
    step(); step(); step();

    // Ack never comes: 16 REQ cycles then an error response with zero data.
    host(1'b0, 2'd1, 32'd0);
    fll_rdata_i = 32'hDEAD_BEEF;
    step();
    req_i = 1'b0;
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      if (fll_req_o === 1'b1 && rvalid_o === 1'b0) cnt_a++;
      step();
    end
    chk("t4_req_cycles", cnt_a,     16);
    chk("t4_rvalid",     rvalid_o,  1);
    chk("t4_err",        err_o,     1);
    chk("t4_rdata",      rdata_o,   0);
    chk("t4_req_lo",     fll_req_o, 0);
    step();

    // Back-to-back requests: grant only in IDLE, one response per grant.
    host(1'b0, 2'd2, 32'd0);
    fll_ack_i   = 1'b1;
    fll_rdata_i = 32'h11;
    cnt_a   = 0;
    cnt_b   = 0;
    cnt_bad = 0;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (gnt_o === 1'b1) cnt_a++;
      if (rvalid_o === 1'b1) cnt_b++;
      if (gnt_o === 1'b1 && (fll_req_o === 1'b1 || rvalid_o === 1'b1)) cnt_bad++;
      step();
    end
    chk("t5_gnts",      cnt_a,   4);
    chk("t5_rvalids",   cnt_b,   4);
    chk("t5_gnt_stall", cnt_bad, 0);
    fll_ack_i = 1'b0;
    step();
    chk("t5_in_req",  fll_req_o, 1);
    chk("t5_gnt_req", gnt_o,     0);
    rst_ni = 1'b0;
    #1;
    chk("t5_rst_req",  fll_req_o, 0);
    chk("t5_rst_wr_n", fll_wr_no, 1);
    req_i = 1'b0;
    step();
    rst_ni = 1'b1;
    cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rvalid_o !== 1'b0) cnt_b++;
    end
    chk("t5_no_resp", cnt_b, 0);

`ifdef FLL_CFG_LOCK_IRQ_EN
    // Lock loss while idle raises the sticky interrupt; addr 3 write clears it locally.
    fll_lock_i = 1'b0;
    step(); step(); step();
    chk("t6_irq_set", lock_irq_o, 1);
    fll_lock_i = 1'b1;
    step(); step(); step();
    chk("t6_irq_sticky", lock_irq_o, 1);
    host(1'b1, 2'd3, 32'h0);
    fll_ack_i = 1'b1;
    #1;
    chk("t6_gnt", gnt_o, 1);
    step();
    req_i = 1'b0;
    chk("t6_irq_clr", lock_irq_o, 0);
    chk("t6_rvalid",  rvalid_o,   1);
    chk("t6_err",     err_o,      0);
    chk("t6_no_req",  fll_req_o,  0);
    step();
    chk("t6_no_req2", fll_req_o, 0);
    fll_ack_i = 1'b0;
`else
    // Without the interrupt option, addr 3 writes reach the FLL normally.
    fll_lock_i = 1'b0;
    step(); step(); step();
    chk("t6_irq_tied", lock_irq_o, 0);
    fll_lock_i = 1'b1;
    host(1'b1, 2'd3, 32'h55);
    fll_ack_i = 1'b1;
    step();
    req_i = 1'b0;
    chk("t6_fwd_req",   fll_req_o,  1);
    chk("t6_fwd_addr",  fll_addr_o, 3);
    chk("t6_fwd_wr_n",  fll_wr_no,  0);
    step();
    chk("t6_fwd_rvalid", rvalid_o, 1);
    chk("t6_fwd_err",    err_o,    0);
    fll_ack_i = 1'b0;
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
